// File: rtl/crypt_round_engine.sv
// crypt_round_engine: iterative 19-bit keyed bit-permutation cipher.
// One round per cycle, valid/ready in and out, handshake counter.
module crypt_round_engine #(
   parameter logic [18:0] KEY = 19'h732F2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [18:0] input_data,
   input  logic        mode,
   input  logic [2:0]  rounds,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [18:0] output_data,
   output logic        busy,
   output logic [15:0] word_count
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [18:0] work_q, work_d;
   logic [18:0] out_q, out_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        mode_q, mode_d;
   logic [15:0] wc_q, wc_d;
   logic [18:0] round_res;
   logic        accept;

   function automatic logic [18:0] dec_round(input logic [18:0] x);
      logic [18:0] t;
      logic [18:0] y;
      t = x ^ KEY;
      for (int i = 0; i < 19; i++) begin
         if (i % 2 == 0) y[i] = ~t[i];
         else            y[i] = t[18-i];
      end
      return y;
   endfunction

   function automatic logic [18:0] enc_round(input logic [18:0] y);
      logic [18:0] t;
      for (int i = 0; i < 19; i++) begin
         if (i % 2 == 0) t[i] = ~y[i];
         else            t[i] = y[18-i];
      end
      return t ^ KEY;
   endfunction

   assign in_ready    = (state_q == IDLE) ||
                        ((state_q == HOLD) && out_ready);
   assign out_valid   = (state_q == HOLD);
   assign busy        = (state_q != IDLE);
   assign output_data = out_q;
   assign word_count  = wc_q;
   assign accept      = in_valid && in_ready;
   assign round_res   = mode_q ? enc_round(work_q)
                               : dec_round(work_q);

   // Next-state: load on accept, iterate rounds, present and hand off.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      wc_d    = wc_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               work_d  = input_data;
               mode_d  = mode;
               cnt_d   = (rounds == 3'd0) ? 4'd8 : {1'b0, rounds};
               state_d = RUN;
            end
         end
         RUN: begin
            work_d = round_res;
            cnt_d  = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               out_d   = round_res;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               wc_d = wc_q + 16'd1;
               if (in_valid) begin
                  work_d  = input_data;
                  mode_d  = mode;
                  cnt_d   = (rounds == 3'd0) ? 4'd8 : {1'b0, rounds};
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         wc_q    <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         wc_q    <= wc_d;
      end
   end

endmodule

// File: tb/tb_crypt_round_engine.sv
// tb_crypt_round_engine: vector table, directed corner sequences and
// randomized jobs against a round-function reference model.
module tb_crypt_round_engine;

   localparam logic [18:0] KEY = 19'h732F2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [18:0] input_data;
   logic        mode;
   logic [2:0]  rounds;
   logic        out_valid;
   logic        out_ready;
   logic [18:0] output_data;
   logic        busy;
   logic [15:0] word_count;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] wc_exp = 16'd0;

   crypt_round_engine #(.KEY(KEY)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .input_data(input_data), .mode(mode), .rounds(rounds),
      .out_valid(out_valid), .out_ready(out_ready),
      .output_data(output_data), .busy(busy),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        m;
      logic [2:0]  r;
      logic [18:0] din;
      logic [18:0] dout;
   } vec_t;

   function automatic logic [18:0] m_dec(input logic [18:0] x);
      logic [18:0] t;
      logic [18:0] y;
      t = x ^ KEY;
      for (int i = 0; i < 19; i++)
         y[i] = (i % 2 == 0) ? ~t[i] : t[18-i];
      return y;
   endfunction

   function automatic logic [18:0] m_enc(input logic [18:0] y);
      logic [18:0] t;
      for (int i = 0; i < 19; i++)
         t[i] = (i % 2 == 0) ? ~y[i] : y[18-i];
      return t ^ KEY;
   endfunction

   function automatic logic [18:0] m_job(input logic m,
                                         input logic [2:0] r,
                                         input logic [18:0] d);
      logic [18:0] v;
      int n;
      n = (r == 3'd0) ? 8 : int'(r);
      v = d;
      for (int k = 0; k < n; k++) v = m ? m_enc(v) : m_dec(v);
      return v;
   endfunction

   task automatic check(input string name, input longint got,
                        input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      tick();
      out_ready = 1'b0;
      wc_exp    = wc_exp + 16'd1;
      check("wc_after_hs", word_count, wc_exp);
      check("idle_after_hs", {out_valid, busy, in_ready}, 3'b001);
   endtask

   task automatic run_job(input string name, input logic m,
                          input logic [2:0] r, input logic [18:0] d,
                          input int hw, input logic [18:0] exp);
      int lat;
      int n;
      n = (r == 3'd0) ? 8 : int'(r);
      check({name, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1; mode = m; rounds = r; input_data = d;
      tick();
      lat = 0;
      while (!out_valid && lat < 20) begin
         in_valid   = 1'($urandom);
         mode       = 1'($urandom);
         rounds     = 3'($urandom);
         input_data = 19'($urandom);
         tick();
         lat++;
      end
      in_valid = 1'b0;
      check({name, "_latency"}, lat, n);
      check({name, "_data"}, output_data, exp);
      for (int k = 0; k < hw; k++) begin
         in_valid   = 1'($urandom);
         input_data = 19'($urandom);
         tick();
         check({name, "_hold_stable"},
               {out_valid, in_ready, output_data}, {2'b10, exp});
      end
      handshake();
   endtask

   vec_t vt[6];

   initial begin
      logic [18:0] a, b, c;
      int lat;
      int hs;
      int cyc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mode = 1'b0; rounds = 3'd0; input_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {out_valid, busy, output_data, word_count},
            {2'b00, 19'h0, 16'h0});
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", {in_ready, busy}, 2'b10);

      vt[0] = '{1'b0, 3'd1, 19'h00000, 19'h26F27};
      vt[1] = '{1'b1, 3'd1, 19'h26F27, 19'h00000};
      vt[2] = '{1'b0, 3'd3, 19'h7FFFF, m_job(1'b0, 3'd3, 19'h7FFFF)};
      vt[3] = '{1'b1, 3'd7, 19'h12345, m_job(1'b1, 3'd7, 19'h12345)};
      vt[4] = '{1'b0, 3'd2, 19'h55555, m_job(1'b0, 3'd2, 19'h55555)};
      vt[5] = '{1'b1, 3'd4, 19'h2AAAA, m_job(1'b1, 3'd4, 19'h2AAAA)};
      for (int i = 0; i < 6; i++)
         run_job($sformatf("vec%0d", i), vt[i].m, vt[i].r,
                 vt[i].din, i % 3, vt[i].dout);

      a = m_job(1'b0, 3'd5, 19'h5A5A5);
      run_job("rt_dec", 1'b0, 3'd5, 19'h5A5A5, 0, a);
      run_job("rt_enc", 1'b1, 3'd5, a, 0, 19'h5A5A5);

      b = 19'h3C0F1;
      c = b;
      for (int k = 0; k < 8; k++) c = m_dec(c);
      run_job("r0_job", 1'b0, 3'd0, b, 0, c);
      a = b;
      for (int k = 0; k < 8; k++) begin
         run_job("r0_chain", 1'b0, 3'd1, a, 0, m_dec(a));
         a = m_dec(a);
      end
      check("r0_chain_eq", a, c);

      a = m_job(1'b0, 3'd3, 19'h1ABCD);
      b = 19'h0F0F0;
      in_valid = 1'b1; mode = 1'b0; rounds = 3'd3; input_data = 19'h1ABCD;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_latency", lat, 3);
      in_valid = 1'b1; input_data = b; mode = 1'b1; rounds = 3'd2;
      for (int k = 0; k < 4; k++) begin
         check("bp_stall", {out_valid, in_ready, output_data},
               {2'b10, a});
         tick();
      end
      check("bp_no_accept", {out_valid, busy, word_count},
            {2'b11, wc_exp});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      mode = 1'b0; rounds = 3'd7;
      wc_exp = wc_exp + 16'd1;
      check("bp_handoff", {out_valid, busy, word_count, output_data},
            {2'b01, wc_exp, a});
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("bp_new_latency", lat, 2);
      check("bp_new_data", output_data, m_enc(m_enc(b)));
      handshake();

      in_valid = 1'b1; mode = 1'b0; rounds = 3'd0; input_data = 19'h11111;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wc_exp = 16'd0;
      check("midrun_rst", {busy, out_valid, output_data, word_count},
            {2'b00, 19'h0, 16'h0});
      check("midrun_rst_ready", in_ready, 1);
      tick();
      check("midrun_idle", {busy, out_valid, word_count}, {2'b00, 16'h0});

      in_valid = 1'b1; out_ready = 1'b1; mode = 1'b0; rounds = 3'd1;
      input_data = 19'h00000;
      hs = 0;
      cyc = 0;
      while (hs < 65536 && cyc < 140000) begin
         tick();
         cyc++;
         if (out_valid) begin
            hs++;
            if (hs == 65536) begin
               in_valid = 1'b0;
               check("wrap_ffff", word_count, 16'hFFFF);
            end
         end
      end
      check("wrap_handshakes", hs, 65536);
      tick();
      out_ready = 1'b0;
      check("wrap_zero", {word_count, busy}, {16'h0, 1'b0});
      wc_exp = 16'd0;

      for (int j = 0; j < 40; j++) begin
         logic        rm;
         logic [2:0]  rr;
         logic [18:0] rd;
         rm = 1'($urandom);
         rr = 3'($urandom);
         rd = 19'($urandom);
         run_job("rand", rm, rr, rd, int'($urandom_range(0, 3)),
                 m_job(rm, rr, rd));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crypt_round_engine.md
CRYPT_ROUND_ENGINE -- requirements
Module: crypt_round_engine

Interface
REQ-001 The block SHALL have one parameter: KEY, default 19'h732F2, 19-bit XOR key used by every round.
REQ-002 The ports SHALL be, one per line, as follows:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  input word offered.
- in_ready  output  1  engine can accept a word.
- input_data  input  19  word to transform.
- mode  input  1  0 = decrypt (D), 1 = encrypt (E); sampled on accept.
- rounds  input  3  round count; 1..7 literal, 0 means 8; sampled on accept.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- output_data  output  19  transformed word.
- busy  output  1  high in RUN or HOLD.
- word_count  output  16  completed output handshakes.

Function
REQ-003 Decrypt round D(x) SHALL be computed as follows:
- t = x XOR KEY.
- For even i: y[i] = NOT t[i].
- For odd i: y[i] = t[18-i].
REQ-004 Encrypt round E(y) SHALL be the exact inverse of D:
- For even i: t[i] = NOT y[i].
- For odd i: t[i] = y[18-i].
- x = t XOR KEY.
- E(D(v)) = v for all v.
REQ-005 The FSM SHALL have three states: IDLE, RUN, HOLD.
REQ-006 IDLE behaviour:
- in_ready = 1.
- On in_valid && in_ready: capture input_data into the working register, latch mode, load round counter with N (rounds, 0 -> 8), go to RUN.
REQ-007 RUN behaviour:
- Each cycle, apply one round (D or E per latched mode) to the working register and decrement the counter.
- After the Nth round, go to HOLD.
- in_ready = 0.
REQ-008 Latency: a word accepted at edge T SHALL present out_valid = 1 with the final result after edge T+N (N in 1..8).
REQ-009 HOLD behaviour:
- out_valid = 1; output_data = working register, stable while out_valid && !out_ready.
- On out_ready: increment word_count.
  - If in_valid is also high in the same cycle: accept the new word (in_ready = out_ready in HOLD), go to RUN.
  - Otherwise go to IDLE.
REQ-010 out_valid SHALL be 0 in IDLE and RUN; output_data SHALL hold its last value outside HOLD.
REQ-011 mode and rounds changes while busy SHALL have no effect on the word in flight.
REQ-012 in_valid SHALL be ignored in RUN.
REQ-013 A word offered in HOLD without out_ready SHALL NOT be accepted.
REQ-014 word_count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-015 busy SHALL equal (state != IDLE).
REQ-016 No combinational path SHALL exist from input_data to output_data; in_ready SHALL depend only on state and out_ready.

Reset
REQ-017 When rst_n = 0 at a rising edge, the block SHALL reset as follows:
- state = IDLE.
- out_valid = 0.
- output_data = 19'h00000.
- word_count = 0.
- Working register and round counter cleared.
- busy = 0.
- in_ready = 1 from the first cycle after reset release.
REQ-018 Reset asserted mid-RUN or in HOLD SHALL discard the in-flight word with no output handshake and no word_count increment.

Verification
REQ-019 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Decrypt, mode=0, rounds=1, input_data=0x00000 -> out_valid one cycle after accept, output_data=0x26F27, word_count=1 after handshake.
- Encrypt, mode=1, rounds=1, input_data=0x26F27 -> output_data=0x00000.
- Round trip: decrypt rounds=5 on 0x5A5A5, feed the result to encrypt rounds=5 -> 0x5A5A5; out_valid exactly 5 cycles after each accept.
- rounds=0 -> exactly 8 round cycles before out_valid; result equals 8 chained single-round results.
- Back-pressure: out_ready low for 4 cycles in HOLD with in_valid high -> output_data stable, in_ready=0, no accept; then out_ready and in_valid high together -> same-cycle handoff, new word enters RUN.
- Reset mid-operation, and word_count wrap:
  - rst_n low in the 3rd RUN cycle of an 8-round job -> next cycle IDLE, out_valid=0, output_data=0, word_count=0.
  - 65536 handshakes -> word_count=0.
